// File: rtl/sva_result_monitor.sv
// Result monitor for the SVA checker: edge-detects succ/fail/lazy_succ, keeps saturating
// counts, queues timestamped records in a FWFT FIFO. Optional: SVA_MON_FIRST_FAIL_TS_EN.
module sva_result_monitor #(
   parameter int CNT_WIDTH  = 16,
   parameter int TS_WIDTH   = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int FAIL_LIMIT = 1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  succ,
   input  logic                  fail,
   input  logic                  lazy_succ,
   output logic                  rec_valid,
   input  logic                  rec_ready,
   output logic [TS_WIDTH+2:0]   rec_data,
   output logic [CNT_WIDTH-1:0]  succ_cnt,
   output logic [CNT_WIDTH-1:0]  fail_cnt,
   output logic [CNT_WIDTH-1:0]  lazy_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic                  overflow,
   output logic                  halted,
   output logic [TS_WIDTH-1:0]   first_fail_ts
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = TS_WIDTH + 3;
   typedef logic [AW:0] occ_t;
   localparam occ_t DEPTH_C = occ_t'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t state_q, state_d;

   logic [TS_WIDTH-1:0] ts_q;
   logic [2:0]          lvl, hist_q, ev;
   logic                act, halt_hit;
   logic [CNT_WIDTH-1:0] succ_d, fail_d, lazy_d;

   logic [RW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   occ_t          occ;
   logic          push_req, pop, full, push, drop;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic e);
      return (e && (c != '1)) ? c + CNT_WIDTH'(1) : c;
   endfunction

   // mask order matches the record layout {fail,lazy,succ}
   assign lvl = {fail, lazy_succ, succ};
   assign ev  = lvl & ~hist_q;
   assign act = (state_q == RUN) && !clear;

   assign succ_d   = sat_inc(succ_cnt, ev[0]);
   assign lazy_d   = sat_inc(lazy_cnt, ev[1]);
   assign fail_d   = sat_inc(fail_cnt, ev[2]);
   assign halt_hit = (FAIL_LIMIT != 0) && ev[2] && (int'(fail_d) == FAIL_LIMIT);

   assign rec_valid = (occ != '0);
   assign full      = (occ == DEPTH_C);
   assign pop       = rec_valid && rec_ready;
   assign push_req  = act && (|ev);
   assign push      = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;
   assign rec_data  = rec_valid ? mem[rd_ptr] : '0;
   assign halted    = (state_q == HALT);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (halt_hit) state_d = HALT;
                  else if (!enable) state_d = IDLE;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
      if (clear) state_d = IDLE;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= IDLE;
         ts_q     <= '0;
         hist_q   <= '0;
         succ_cnt <= '0;
         fail_cnt <= '0;
         lazy_cnt <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
      end else begin
         state_q <= state_d;
         ts_q    <= ts_q + TS_WIDTH'(1);
         hist_q  <= lvl;
         if (clear) begin
            succ_cnt <= '0;
            fail_cnt <= '0;
            lazy_cnt <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
         end else begin
            if (act) begin
               succ_cnt <= succ_d;
               fail_cnt <= fail_d;
               lazy_cnt <= lazy_d;
            end
            if (drop) begin
               drop_cnt <= sat_inc(drop_cnt, 1'b1);
               overflow <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            // simultaneous push and pop leaves occupancy unchanged
            if (push && !pop)      occ <= occ + occ_t'(1);
            else if (pop && !push) occ <= occ - occ_t'(1);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push && !clear) mem[wr_ptr] <= {ev, ts_q};
   end

`ifdef SVA_MON_FIRST_FAIL_TS_EN
   logic ff_seen_q;
   logic [TS_WIDTH-1:0] ff_ts_q;
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ff_seen_q <= 1'b0;
         ff_ts_q   <= '0;
      end else if (clear) begin
         ff_seen_q <= 1'b0;
         ff_ts_q   <= '0;
      end else if (act && ev[2] && !ff_seen_q) begin
         ff_seen_q <= 1'b1;
         ff_ts_q   <= ts_q;
      end
   end
   assign first_fail_ts = ff_ts_q;
`else
   assign first_fail_ts = '0;
`endif

endmodule

// File: tb/tb_sva_result_monitor.sv
// Scoreboard bench for sva_result_monitor: records queued on stimulus, compared on pop.
module tb_sva_result_monitor;
   localparam int CW = 4;
   localparam int TW = 32;
   localparam int DEPTH = 8;

   logic sys_clk = 1'b0, sys_rst_n = 1'b0;
   logic enable = 1'b0, clear = 1'b0, succ = 1'b0, fail = 1'b0, lazy_succ = 1'b0, rec_ready = 1'b0;
   logic rec_valid, overflow, halted;
   logic [TW+2:0] rec_data;
   logic [CW-1:0] succ_cnt, fail_cnt, lazy_cnt, drop_cnt;
   logic [TW-1:0] first_fail_ts;

   logic n_rec_valid, n_overflow, n_halted;
   logic [TW+2:0] n_rec_data;
   logic [15:0] n_succ_cnt, n_fail_cnt, n_lazy_cnt, n_drop_cnt;
   logic [TW-1:0] n_first_fail_ts;

   int nchk = 0, nfail = 0;
   logic [TW-1:0] tb_ts;
   logic [TW+2:0] sb[$];

   sva_result_monitor #(.CNT_WIDTH(CW), .TS_WIDTH(TW), .FIFO_DEPTH(DEPTH), .FAIL_LIMIT(2)) u_dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .clear(clear),
      .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
      .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .lazy_cnt(lazy_cnt), .drop_cnt(drop_cnt),
      .overflow(overflow), .halted(halted), .first_fail_ts(first_fail_ts));

   sva_result_monitor #(.CNT_WIDTH(16), .TS_WIDTH(TW), .FIFO_DEPTH(DEPTH), .FAIL_LIMIT(0)) u_nolim (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .clear(clear),
      .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
      .rec_valid(n_rec_valid), .rec_ready(rec_ready), .rec_data(n_rec_data),
      .succ_cnt(n_succ_cnt), .fail_cnt(n_fail_cnt), .lazy_cnt(n_lazy_cnt), .drop_cnt(n_drop_cnt),
      .overflow(n_overflow), .halted(n_halted), .first_fail_ts(n_first_fail_ts));

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) tb_ts <= '0;
      else            tb_ts <= tb_ts + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // pops happen at the next posedge; compare the head now
   always @(negedge sys_clk) begin
      #1;
      if (sys_rst_n && rec_valid && rec_ready) begin
         if (sb.size() == 0) chk("rec_unexpected", 64'(sb.size()), 64'd1);
         else chk("rec_data", 64'(rec_data), 64'(sb.pop_front()));
      end
   end

   task automatic tick();
      @(negedge sys_clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 64'(rec_valid), 0);
      chk({tag, "_data"},  64'(rec_data), 0);
      chk({tag, "_succ"},  64'(succ_cnt), 0);
      chk({tag, "_fail"},  64'(fail_cnt), 0);
      chk({tag, "_lazy"},  64'(lazy_cnt), 0);
      chk({tag, "_drop"},  64'(drop_cnt), 0);
      chk({tag, "_ovf"},   64'(overflow), 0);
      chk({tag, "_halt"},  64'(halted), 0);
      chk({tag, "_ffts"},  64'(first_fail_ts), 0);
   endtask

   task automatic do_reset();
      tick();
      sys_rst_n = 1'b0;
      {enable, clear, succ, fail, lazy_succ, rec_ready} = '0;
      sb.delete();
      #1 chk_zero("reset");
      tick();
      tick();
      sys_rst_n = 1'b1;
   endtask

   task automatic wait_ts(input logic [TW-1:0] t);
      for (int i = 0; i < 200 && tb_ts != t; i++) tick();
      chk("wait_ts", 64'(tb_ts), 64'(t));
   endtask

   task automatic pulse(input logic [2:0] m, input bit exp_push);
      {fail, lazy_succ, succ} = m;
      if (exp_push && sb.size() < DEPTH) sb.push_back({m, tb_ts});
      tick();
      {fail, lazy_succ, succ} = 3'b000;
      tick();
   endtask

   task automatic drain(input string tag);
      rec_ready = 1'b1;
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      tick();
      chk({tag, "_sb_empty"}, 64'(sb.size()), 0);
      chk({tag, "_valid_low"}, 64'(rec_valid), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // single succ pulse spanning 3 cycles
      do_reset();
      enable = 1'b1;
      wait_ts(10);
      succ = 1'b1;
      sb.push_back({3'b001, 32'd10});
      tick();
      chk("t1_succ_lat", 64'(succ_cnt), 1);
      chk("t1_valid_lat", 64'(rec_valid), 1);
      tick(); tick();
      succ = 1'b0;
      tick();
      chk("t1_succ_once", 64'(succ_cnt), 1);
      drain("t1");

      // simultaneous succ+fail produce one combined record
      do_reset();
      enable = 1'b1;
      rec_ready = 1'b1;
      wait_ts(20);
      {fail, succ} = 2'b11;
      sb.push_back({3'b101, 32'd20});
      tick();
      chk("t2_succ", 64'(succ_cnt), 1);
      chk("t2_fail", 64'(fail_cnt), 1);
      chk("t2_halt", 64'(halted), 0);
      {fail, succ} = 2'b00;
      drain("t2");

      // overflow: 10 edges into 8 entries
      do_reset();
      enable = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) pulse(3'b001, 1'b1);
      chk("t3_succ", 64'(succ_cnt), 10);
      chk("t3_drop", 64'(drop_cnt), 2);
      chk("t3_ovf", 64'(overflow), 1);
      chk("t3_held", 64'(sb.size()), 8);
      drain("t3");

      // fail-limit halt
      do_reset();
      enable = 1'b1;
      rec_ready = 1'b1;
      wait_ts(5);
      fail = 1'b1;
      sb.push_back({3'b100, 32'd5});
      tick();
      fail = 1'b0;
      chk("t4_not_halted", 64'(halted), 0);
      wait_ts(9);
      fail = 1'b1;
      sb.push_back({3'b100, 32'd9});
      tick();
      fail = 1'b0;
      chk("t4_halted", 64'(halted), 1);
      chk("t4_fail", 64'(fail_cnt), 2);
      pulse(3'b001, 1'b0);
      tick();
      chk("t4_succ_blocked", 64'(succ_cnt), 0);
      chk("t4_still_halted", 64'(halted), 1);
      chk("t4_drop", 64'(drop_cnt), 0);
`ifdef SVA_MON_FIRST_FAIL_TS_EN
      chk("t4_ffts", 64'(first_fail_ts), 5);
`else
      chk("t4_ffts", 64'(first_fail_ts), 0);
`endif
      chk("t4_nolim_halt", 64'(n_halted), 0);
      chk("t4_nolim_fail", 64'(n_fail_cnt), 2);
      chk("t4_nolim_succ", 64'(n_succ_cnt), 1);
      drain("t4");
      clear = 1'b1;
      tick();
      clear = 1'b0;
      sb.delete();
      chk("t4_clr_halt", 64'(halted), 0);
      chk("t4_clr_fail", 64'(fail_cnt), 0);
      chk("t4_clr_ffts", 64'(first_fail_ts), 0);

      // lazy counter saturation
      do_reset();
      enable = 1'b1;
      rec_ready = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) pulse(3'b010, 1'b1);
      chk("t5_lazy_sat", 64'(lazy_cnt), 15);
      chk("t5_ovf", 64'(overflow), 0);
      drain("t5");

      // held flag on enable, clear, async reset mid-burst
      do_reset();
      succ = 1'b1;
      tick(); tick();
      enable = 1'b1;
      tick(); tick(); tick();
      chk("t6_no_ev_on_en", 64'(succ_cnt), 0);
      chk("t6_no_rec_on_en", 64'(rec_valid), 0);
      succ = 1'b0;
      tick();
      pulse(3'b001, 1'b1);
      chk("t6_succ", 64'(succ_cnt), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      sb.delete();
      chk("t6_clr_succ", 64'(succ_cnt), 0);
      chk("t6_clr_valid", 64'(rec_valid), 0);
      fail = 1'b1;
      tick();
      chk("t6_idle_after_clr", 64'(fail_cnt), 0);
      fail = 1'b0;
      tick();
      pulse(3'b010, 1'b1);
      pulse(3'b010, 1'b1);
      chk("t6_lazy", 64'(lazy_cnt), 2);
      chk("t6_valid", 64'(rec_valid), 1);
      #3 sys_rst_n = 1'b0;
      sb.delete();
      #1 chk_zero("t6_async");
      tick();
      sys_rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
